// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stage link: one producer (master) drives an item, one consumer (slave) accepts it.
// A transfer happens on a clock edge where valid and ready are both high.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush-to-bubble and a saturating downstream stall counter.
module pipe_stage_buf #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_buf_if.slave  up,
    pipe_stage_buf_if.master dn,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    logic              out_valid;
    logic              in_ready;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = up.valid & in_ready;
    assign out_fire = out_valid & dn.ready;

    generate
        if (SKID != 0) begin : g_skid
            state_t            state_q,     state_d;
            logic              in_ready_q,  in_ready_d;
            logic              out_valid_q, out_valid_d;
            logic [1:0]        occ_q,       occ_d;
            logic [DATA_W-1:0] main_data_q, main_data_d;
            logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
            logic [DATA_W-1:0] skid_data_q, skid_data_d;
            logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

            always_comb begin
                state_d     = state_q;
                main_data_d = main_data_q;
                main_ctrl_d = main_ctrl_q;
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            main_data_d = up.data;
                            main_ctrl_d = up.ctrl;
                            state_d     = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (in_fire && out_fire) begin
                            main_data_d = up.data;
                            main_ctrl_d = up.ctrl;
                        end else if (in_fire) begin
                            // Head is stalled: park the new item behind it.
                            skid_data_d = up.data;
                            skid_ctrl_d = up.ctrl;
                            state_d     = ST_TWO;
                        end else if (out_fire) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (out_fire) begin
                            main_data_d = skid_data_q;
                            main_ctrl_d = skid_ctrl_q;
                            state_d     = ST_ONE;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
                // Flush drops everything held; stale data is harmless since valid clears.
                if (flush) begin
                    state_d = ST_EMPTY;
                end
                in_ready_d  = (state_d != ST_TWO);
                out_valid_d = (state_d != ST_EMPTY);
                occ_d       = state_d;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    occ_q       <= 2'd0;
                    main_data_q <= '0;
                    main_ctrl_q <= '0;
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else begin
                    state_q     <= state_d;
                    in_ready_q  <= in_ready_d;
                    out_valid_q <= out_valid_d;
                    occ_q       <= occ_d;
                    main_data_q <= main_data_d;
                    main_ctrl_q <= main_ctrl_d;
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = out_valid_q;
            assign main_data = main_data_q;
            assign main_ctrl = main_ctrl_q;
            assign occupancy = occ_q;
        end else begin : g_single
            logic              valid_q,     valid_d;
            logic [DATA_W-1:0] main_data_q, main_data_d;
            logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;

            // Ready passes straight through from downstream when the entry is occupied.
            assign in_ready = ~valid_q | dn.ready;

            always_comb begin
                valid_d     = valid_q;
                main_data_d = main_data_q;
                main_ctrl_d = main_ctrl_q;
                if (in_fire) begin
                    main_data_d = up.data;
                    main_ctrl_d = up.ctrl;
                    valid_d     = 1'b1;
                end else if (out_fire) begin
                    valid_d = 1'b0;
                end
                if (flush) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q     <= 1'b0;
                    main_data_q <= '0;
                    main_ctrl_q <= '0;
                end else begin
                    valid_q     <= valid_d;
                    main_data_q <= main_data_d;
                    main_ctrl_q <= main_ctrl_d;
                end
            end

            assign out_valid = valid_q;
            assign main_data = main_data_q;
            assign main_ctrl = main_ctrl_q;
            assign occupancy = {1'b0, valid_q};
        end
    endgenerate

    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !dn.ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
    assign up.ready     = in_ready;
    assign dn.valid     = out_valid;
    assign dn.data      = main_data;
    // Control is zeroed for bubbles so no side-effect can leak downstream.
    assign dn.ctrl      = main_ctrl & {CTRL_W{out_valid}};
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (skid, single-entry, narrow counter)
// with per-instance scoreboards checking order, content and bubble masking.
module tb_pipe_stage_buf;
    localparam int DW = 96;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) up_a ();
    pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) dn_a ();
    pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) up_b ();
    pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) dn_b ();
    pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) up_c ();
    pipe_stage_buf_if #(.DATA_W(DW), .CTRL_W(CW)) dn_c ();

    logic [1:0]  occ_a, occ_b, occ_c;
    logic [15:0] stall_a, stall_b;
    logic [3:0]  stall_c;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .up(up_a), .dn(dn_a),
        .occupancy(occ_a), .stall_cycles(stall_a));
    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .up(up_b), .dn(dn_b),
        .occupancy(occ_b), .stall_cycles(stall_b));
    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .up(up_c), .dn(dn_c),
        .occupancy(occ_c), .stall_cycles(stall_c));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Flattened views so one generate loop can monitor all three instances.
    logic          uv [3];
    logic          ur [3];
    logic          ov [3];
    logic          orr[3];
    logic [DW-1:0] ud [3];
    logic [DW-1:0] od [3];
    logic [CW-1:0] uc [3];
    logic [CW-1:0] oc [3];

    assign uv[0] = up_a.valid; assign ur[0] = up_a.ready; assign ud[0] = up_a.data; assign uc[0] = up_a.ctrl;
    assign uv[1] = up_b.valid; assign ur[1] = up_b.ready; assign ud[1] = up_b.data; assign uc[1] = up_b.ctrl;
    assign uv[2] = up_c.valid; assign ur[2] = up_c.ready; assign ud[2] = up_c.data; assign uc[2] = up_c.ctrl;
    assign ov[0] = dn_a.valid; assign orr[0] = dn_a.ready; assign od[0] = dn_a.data; assign oc[0] = dn_a.ctrl;
    assign ov[1] = dn_b.valid; assign orr[1] = dn_b.ready; assign od[1] = dn_b.data; assign oc[1] = dn_b.ctrl;
    assign ov[2] = dn_c.valid; assign orr[2] = dn_c.ready; assign od[2] = dn_c.data; assign oc[2] = dn_c.ctrl;

    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        logic [DW+CW-1:0] sb[$];
        logic [DW+CW-1:0] exp_item;
        int               n_out = 0;

        // Sampled mid-cycle: a handshake seen here completes at the next rising edge.
        always @(negedge clk) begin
            if (reset) begin
                sb.delete();
            end else begin
                if (ov[gi] && orr[gi]) begin
                    check_eq($sformatf("d%0d_sb_nonempty", gi), 128'(sb.size() != 0), 128'd1);
                    if (sb.size() != 0) begin
                        exp_item = sb.pop_front();
                        n_out++;
                        $display("d%0d out data=0x%0h ctrl=0x%0h", gi, od[gi], oc[gi]);
                        check_eq($sformatf("d%0d_out_data", gi), 128'(od[gi]), 128'(exp_item[DW-1:0]));
                        check_eq($sformatf("d%0d_out_ctrl", gi), 128'(oc[gi]), 128'(exp_item[DW+CW-1:DW]));
                    end
                end
                if (!ov[gi]) begin
                    check_eq($sformatf("d%0d_bubble_ctrl", gi), 128'(oc[gi]), 128'd0);
                end
                if (flush) begin
                    sb.delete();
                end else if (uv[gi] && ur[gi]) begin
                    sb.push_back({uc[gi], ud[gi]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        int  cyc;
        logic fire;

        up_a.valid = 1'b0; up_a.data = '0; up_a.ctrl = '0; dn_a.ready = 1'b1;
        up_b.valid = 1'b0; up_b.data = '0; up_b.ctrl = '0; dn_b.ready = 1'b1;
        up_c.valid = 1'b0; up_c.data = '0; up_c.ctrl = '0; dn_c.ready = 1'b1;

        // Reset values, observed before any clock edge
        #1 reset = 1'b1;
        #1;
        check_eq("rst_in_ready", 128'(up_a.ready), 128'd1);
        check_eq("rst_out_valid", 128'(dn_a.valid), 128'd0);
        check_eq("rst_out_ctrl", 128'(dn_a.ctrl), 128'd0);
        check_eq("rst_out_data", 128'(dn_a.data), 128'd0);
        check_eq("rst_occ", 128'(occ_a), 128'd0);
        check_eq("rst_stall", 128'(stall_a), 128'd0);
        check_eq("rst_occ_b", 128'(occ_b), 128'd0);
        tick();
        tick();
        reset = 1'b0;

        // Streaming with downstream always ready: 1-cycle latency, no stalls
        dn_a.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up_a.valid = 1'b1;
            up_a.data  = DW'(32'h11 * (i + 1));
            up_a.ctrl  = CW'(i + 1);
            tick();
            check_eq("t1_in_ready", 128'(up_a.ready), 128'd1);
            check_eq("t1_out_valid", 128'(dn_a.valid), 128'd1);
            check_eq("t1_out_data", 128'(dn_a.data), 128'(32'h11 * (i + 1)));
        end
        up_a.valid = 1'b0;
        tick();
        check_eq("t1_drained", 128'(dn_a.valid), 128'd0);
        check_eq("t1_stall", 128'(stall_a), 128'd0);

        // Fill the skid buffer, then drain
        do_reset();
        dn_a.ready = 1'b0;
        up_a.valid = 1'b1; up_a.data = DW'(32'hA); up_a.ctrl = CW'(16'h0101);
        tick();
        check_eq("t2_occ1", 128'(occ_a), 128'd1);
        check_eq("t2_ready1", 128'(up_a.ready), 128'd1);
        up_a.data = DW'(32'hB); up_a.ctrl = CW'(16'h0202);
        tick();
        up_a.valid = 1'b0;
        check_eq("t2_occ2", 128'(occ_a), 128'd2);
        check_eq("t2_ready2", 128'(up_a.ready), 128'd0);
        check_eq("t2_stall1", 128'(stall_a), 128'd1);
        tick();
        check_eq("t2_stall2", 128'(stall_a), 128'd2);
        dn_a.ready = 1'b1;
        tick();
        check_eq("t2_head_b", 128'(dn_a.data), 128'hB);
        check_eq("t2_occ_after_drain", 128'(occ_a), 128'd1);
        check_eq("t2_ready_after_drain", 128'(up_a.ready), 128'd1);
        check_eq("t2_stall_hold", 128'(stall_a), 128'd2);
        tick();
        check_eq("t2_empty", 128'(occ_a), 128'd0);

        // Flush while full, then flush swallowing a same-cycle input
        do_reset();
        dn_a.ready = 1'b0;
        up_a.valid = 1'b1; up_a.data = DW'(32'hD1); up_a.ctrl = CW'(16'hFFFF);
        tick();
        up_a.data = DW'(32'hD2);
        tick();
        check_eq("t3_occ2", 128'(occ_a), 128'd2);
        up_a.data = DW'(32'hC); flush = 1'b1;
        tick();
        flush = 1'b0; up_a.valid = 1'b0;
        check_eq("t3_flush_valid", 128'(dn_a.valid), 128'd0);
        check_eq("t3_flush_ctrl", 128'(dn_a.ctrl), 128'd0);
        check_eq("t3_flush_occ", 128'(occ_a), 128'd0);
        check_eq("t3_flush_ready", 128'(up_a.ready), 128'd1);
        up_a.valid = 1'b1; up_a.data = DW'(32'hE1); up_a.ctrl = CW'(16'hFFFF);
        tick();
        up_a.data = DW'(32'hC); flush = 1'b1;
        tick();
        flush = 1'b0; up_a.valid = 1'b0;
        check_eq("t3_flush2_occ", 128'(occ_a), 128'd0);
        dn_a.ready = 1'b1;
        repeat (3) tick();
        check_eq("t3_no_c", 128'(dn_a.valid), 128'd0);

        // Single-entry stage with toggling downstream ready
        do_reset();
        idx = 0;
        cyc = 0;
        while (idx < 5 && cyc < 40) begin
            dn_b.ready = (cyc % 2 == 0);
            up_b.valid = 1'b1;
            up_b.data  = DW'(idx + 1);
            up_b.ctrl  = CW'(16'h10 + idx);
            #1;
            if (dn_b.valid) begin
                check_eq("t4_ready_tracks", 128'(up_b.ready), 128'(dn_b.ready));
            end
            fire = up_b.ready;
            tick();
            if (fire) idx++;
            cyc++;
        end
        check_eq("t4_all_pushed", 128'(idx), 128'd5);
        up_b.valid = 1'b0;
        dn_b.ready = 1'b1;
        for (int k = 0; k < 10 && g_mon[1].n_out < 5; k++) tick();
        check_eq("t4_all_out", 128'(g_mon[1].n_out), 128'd5);

        // Narrow stall counter saturation
        do_reset();
        dn_c.ready = 1'b0;
        up_c.valid = 1'b1; up_c.data = DW'(32'h55); up_c.ctrl = CW'(16'h0007);
        tick();
        up_c.valid = 1'b0;
        repeat (10) tick();
        check_eq("t5_stall10", 128'(stall_c), 128'd10);
        repeat (10) tick();
        check_eq("t5_stall_sat", 128'(stall_c), 128'd15);
        repeat (3) tick();
        check_eq("t5_stall_hold", 128'(stall_c), 128'd15);
        dn_c.ready = 1'b1;
        tick();
        check_eq("t5_drained", 128'(occ_c), 128'd0);

        // Asynchronous reset while full
        do_reset();
        dn_a.ready = 1'b0;
        up_a.valid = 1'b1; up_a.data = DW'(32'h61); up_a.ctrl = CW'(16'h00F0);
        tick();
        up_a.data = DW'(32'h62);
        tick();
        up_a.valid = 1'b0;
        tick();
        check_eq("t6_occ2", 128'(occ_a), 128'd2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_valid", 128'(dn_a.valid), 128'd0);
        check_eq("t6_ctrl", 128'(dn_a.ctrl), 128'd0);
        check_eq("t6_occ", 128'(occ_a), 128'd0);
        check_eq("t6_stall", 128'(stall_a), 128'd0);
        check_eq("t6_ready", 128'(up_a.ready), 128'd1);
        tick();
        tick();
        reset = 1'b0;
        dn_a.ready = 1'b1;
        repeat (3) tick();
        check_eq("t6_stays_empty", 128'(dn_a.valid), 128'd0);

        check_eq("d0_sb_empty", 128'(g_mon[0].sb.size()), 128'd0);
        check_eq("d1_sb_empty", 128'(g_mon[1].sb.size()), 128'd0);
        check_eq("d2_sb_empty", 128'(g_mon[2].sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register and successor to the fixed-field stage registers between ID/EX, EX/MEM and MEM/WB.
- Carries a generic payload (operands, PC) and a control bundle (reg_write, mem_write, writeback select, …) with a valid/ready handshake, so any stage can stall independently.
- SKID=1 gives a 2-entry skid buffer with registered in_ready, which breaks the ready path; SKID=0 gives a single entry.
- Synchronous flush inserts a bubble whose control bits are zero, so no side-effects escape.

Parameters:
- DATA_W, 96, payload width in bits.
- CTRL_W, 16, control-bundle width; all-zero means no side-effects.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush (branch/jump redirect).
- in_valid  input  1  upstream item valid.
- in_ready  output  1  stage can accept; transfer when in_valid & in_ready.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bundle.
- out_valid  output  1  downstream item valid.
- out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
- out_data  output  DATA_W  payload of head entry.
- out_ctrl  output  CTRL_W  control of head entry; forced 0 whenever out_valid=0.
- occupancy  output  2  entries held (0..2; max 1 when SKID=0).
- stall_cycles  output  CNT_W  saturating count of cycles with out_valid & !out_ready.

Behaviour:
- Reset (async, while reset=1):
  - state=EMPTY, out_valid=0, out_data=0, out_ctrl=0, skid regs=0.
  - occupancy=0, stall_cycles=0.
  - in_ready=1 (SKID=1). Inputs are ignored while reset is high.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: 1 cycle. An item accepted at edge N appears on out_* after edge N, when the stage was EMPTY or drained the same cycle.
- SKID=1 state machine (head = main reg, skid = second reg):
  - EMPTY: in_fire -> main<=in, go ONE. Otherwise stay.
  - ONE:
    - in_fire & out_fire -> main<=in, stay ONE.
    - in_fire & !out_fire -> skid<=in, go TWO.
    - !in_fire & out_fire -> go EMPTY.
    - Neither -> hold.
  - TWO: in_ready=0. out_fire -> main<=skid, go ONE. Otherwise hold.
  - in_ready is a flop: next value = (next_state != TWO).
- SKID=0: a single main register.
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire -> main<=in, valid=1. out_fire & !in_fire -> valid=0.
- Ordering: strictly FIFO; no item is dropped or duplicated except by flush.
- Flush has the highest priority below reset:
  - Next state EMPTY; out_valid=0 and out_ctrl=0 on the following cycle.
  - Data registers may hold stale values.
  - An in_fire in the flush cycle is consumed and discarded.
  - An out_fire in the flush cycle still completes downstream.
  - in_ready becomes 1 after the flush edge.
- Bubble rule: out_ctrl = main_ctrl & {CTRL_W{out_valid}}. Data is not masked.
- Stall counter:
  - Increments when out_valid & !out_ready, including the flush cycle.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- occupancy: EMPTY=0, ONE=1, TWO=2.
- Reset asserted mid-transfer: all contents are lost immediately and outputs go to reset values without waiting for clk.

Test Plan:
- Reset then stream 0x11,0x22,0x33 with out_ready=1 held: each item appears 1 cycle after acceptance, in_ready stays 1, stall_cycles=0.
- SKID=1, out_ready=0, push 0xA then 0xB: occupancy 1 then 2, in_ready=0 after 2nd edge, stall_cycles counts. Then raise out_ready: outputs 0xA, then 0xB, in_ready=1 one cycle after the first drain.
- Occupancy 2 with in_ctrl=0xFFFF entries, assert flush with in_valid=1 and data 0xC: next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xC never appears at out_*.
- SKID=0, out_ready toggling 1,0,1 with continuous input 1..5: in_ready tracks out_ready when full, all 5 items emerge in order with none lost.
- CNT_W=4, out_valid=1, out_ready=0 for 20 cycles: stall_cycles saturates at 15 and holds.
- Assert reset asynchronously between edges while occupancy=2: out_valid, out_ctrl, occupancy and stall_cycles drop to 0 before the next clk edge; in_ready=1.
